// File: rtl/spi_slave_6502_pkg.sv
// Shared types and constants for the SPI peripheral-mode endpoint on the 6502 bus.
package spi_slave_6502_pkg;

    // Frame sequencing states
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACTIVE   = 2'd1,
        COMPLETE = 2'd2,
        WAIT_CS  = 2'd3
    } state_e;

    // STATUS register bit positions
    localparam int unsigned STAT_RX_VALID  = 0;
    localparam int unsigned STAT_BUSY      = 1;
    localparam int unsigned STAT_OVERRUN   = 2;
    localparam int unsigned STAT_FRAME_ERR = 3;

    // Register window layout as a function of bytes per frame (n)
    function automatic int unsigned rx_off(input int unsigned n);
        return n;
    endfunction

    function automatic int unsigned status_off(input int unsigned n);
        return 2 * n;
    endfunction

    function automatic int unsigned ctrl_off(input int unsigned n);
        return 2 * n + 1;
    endfunction

    function automatic int unsigned window_size(input int unsigned n);
        return 2 * n + 2;
    endfunction

endpackage

// File: rtl/spi_slave_6502_sync_edge.sv
// Multi-flop synchronizer for an asynchronous input plus one-flop edge detect.
// All flops reset to 0, so an edge is only reported after the synchronized
// level has actually been seen to change since reset.
module sync_edge #(
    parameter int unsigned Stages = 2
) (
    input  logic clk_i,
    input  logic reset_ni,
    input  logic d_i,
    output logic sync_o,
    output logic rise_o,
    output logic fall_o
);

    logic [Stages-1:0] chain_q;
    logic              prev_q;

    // Shift the raw input through the synchronizer and keep last synced level
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            chain_q <= '0;
            prev_q  <= 1'b0;
        end else begin
            chain_q <= {chain_q[Stages-2:0], d_i};
            prev_q  <= chain_q[Stages-1];
        end
    end

    assign sync_o = chain_q[Stages-1];
    assign rise_o = chain_q[Stages-1] & ~prev_q;
    assign fall_o = ~chain_q[Stages-1] & prev_q;

endmodule

// File: rtl/spi_slave_6502.sv
// SPI mode-0 peripheral endpoint exchanging fixed-length frames with an external
// host; the CPU sees TX/RX buffers, STATUS and CTRL in a memory-mapped window.
module spi_slave_6502
    import spi_slave_6502_pkg::*;
#(
    parameter int unsigned BaseAddress         = 'h9400,
    parameter int unsigned BytesPerTransaction = 4,
    parameter int unsigned address_width       = 16,
    parameter int unsigned data_width          = 8,
    parameter int unsigned SyncStages          = 2
) (
    input  logic                     clk_i,
    input  logic                     reset_ni,
    input  logic [address_width-1:0] address_i,
    input  logic [data_width-1:0]    data_i,
    input  logic                     rd_wr_i,
    output logic [data_width-1:0]    data_o,
    input  logic                     spi_clk_i,
    input  logic                     spi_cs_ni,
    input  logic                     spi_mosi_i,
    output logic                     spi_miso_o,
    output logic                     irq_o
);

    localparam int unsigned N          = BytesPerTransaction;
    localparam int unsigned FRAME_BITS = 8 * N;
    localparam int unsigned CNT_W      = $clog2(FRAME_BITS + 1);

    localparam logic [CNT_W-1:0]         LAST_BIT = CNT_W'(FRAME_BITS - 1);
    localparam logic [address_width-1:0] BASE_A   = address_width'(BaseAddress);
    localparam logic [address_width-1:0] RX_A     = address_width'(rx_off(N));
    localparam logic [address_width-1:0] STATUS_A = address_width'(status_off(N));
    localparam logic [address_width-1:0] CTRL_A   = address_width'(ctrl_off(N));
    localparam logic [address_width-1:0] WIN_A    = address_width'(window_size(N));

    // ---------------- synchronizers ----------------
    logic sclk_rise, sclk_fall, sclk_lvl_unused;
    logic cs_sync, cs_fall, cs_rise_unused;
    logic [SyncStages-1:0] mosi_sync_q;
    logic mosi_sync;

    // SCLK level is not needed; only its edges drive the shifters.
    sync_edge #(.Stages(SyncStages)) u_sclk (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .d_i      (spi_clk_i),
        .sync_o   (sclk_lvl_unused),
        .rise_o   (sclk_rise),
        .fall_o   (sclk_fall)
    );

    // CS is tracked as a level for frame end, so its rise pulse is not needed.
    sync_edge #(.Stages(SyncStages)) u_cs (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .d_i      (spi_cs_ni),
        .sync_o   (cs_sync),
        .rise_o   (cs_rise_unused),
        .fall_o   (cs_fall)
    );

    // MOSI uses the same depth as SCLK so the sampled bit lines up with the rise
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) mosi_sync_q <= '0;
        else           mosi_sync_q <= {mosi_sync_q[SyncStages-2:0], spi_mosi_i};
    end
    assign mosi_sync = mosi_sync_q[SyncStages-1];

    // ---------------- frame state machine ----------------
    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
    logic [FRAME_BITS-1:0]   tx_shift_q, tx_shift_d;
    logic [FRAME_BITS-1:0]   rx_shift_q, rx_shift_d;
    logic                    miso_q, miso_d;
    logic [FRAME_BITS-1:0]   tx_concat;
    logic                    capture;
    logic                    set_ferr;

    logic [7:0]              tx_q [N];
    logic [7:0]              tx_d [N];
    logic [7:0]              rx_q [N];
    logic [7:0]              rx_d [N];

    // TX buffer flattened with byte 0 in the MSBs so it is shifted out first
    always_comb begin
        tx_concat = '0;
        for (int i = 0; i < int'(N); i++) begin
            tx_concat[FRAME_BITS-1-8*i -: 8] = tx_q[i];
        end
    end

    // Next state, shifters, bit counter and the capture/error strobes
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        tx_shift_d = tx_shift_q;
        rx_shift_d = rx_shift_q;
        capture    = 1'b0;
        set_ferr   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    tx_shift_d = tx_concat;
                    bit_cnt_d  = '0;
                    state_d    = ACTIVE;
                end
            end
            ACTIVE: begin
                if (sclk_rise) begin
                    rx_shift_d = {rx_shift_q[FRAME_BITS-2:0], mosi_sync};
                    bit_cnt_d  = bit_cnt_q + CNT_W'(1);
                end
                if (sclk_fall) begin
                    tx_shift_d = {tx_shift_q[FRAME_BITS-2:0], 1'b0};
                end
                // The last bit wins over a CS rise seen in the same cycle
                if (sclk_rise && (bit_cnt_q == LAST_BIT)) begin
                    state_d = COMPLETE;
                end else if (cs_sync) begin
                    set_ferr = 1'b1;
                    state_d  = IDLE;
                end
            end
            COMPLETE: begin
                capture = 1'b1;
                state_d = WAIT_CS;
            end
            WAIT_CS: begin
                // Level test, so a CS rise that coincided with the last bit is not lost
                if (cs_sync) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        miso_d = (state_d == ACTIVE) ? tx_shift_d[FRAME_BITS-1] : 1'b0;
    end

    // Frame-side registers
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            tx_shift_q <= '0;
            rx_shift_q <= '0;
            miso_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            tx_shift_q <= tx_shift_d;
            rx_shift_q <= rx_shift_d;
            miso_q     <= miso_d;
        end
    end

    assign spi_miso_o = miso_q;

    // ---------------- CPU register window ----------------
    logic [address_width-1:0] offset;
    logic                     hit, wr_en, rd_en, busy;
    logic [3:0]               w1c;
    logic [7:0]               rd_data;
    logic                     rx_valid_q, rx_valid_d;
    logic                     overrun_q, overrun_d;
    logic                     frame_err_q, frame_err_d;
    logic                     irq_en_q, irq_en_d;
    logic                     irq_q, irq_d;
    logic [data_width-1:0]    data_q, data_d;

    assign offset = address_i - BASE_A;
    assign hit    = (address_i >= BASE_A) && (offset < WIN_A);
    assign wr_en  = hit & rd_wr_i;
    assign rd_en  = hit & ~rd_wr_i;
    assign busy   = (state_q != IDLE);

    // Read mux over the window; unused bits and offsets read 0
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (offset == address_width'(i))        rd_data = tx_q[i];
            if (offset == RX_A + address_width'(i)) rd_data = rx_q[i];
        end
        if (offset == STATUS_A) begin
            rd_data[STAT_RX_VALID]  = rx_valid_q;
            rd_data[STAT_BUSY]      = busy;
            rd_data[STAT_OVERRUN]   = overrun_q;
            rd_data[STAT_FRAME_ERR] = frame_err_q;
        end
        if (offset == CTRL_A) rd_data[0] = irq_en_q;
    end

    // CPU writes, frame capture and sticky flags; hardware sets beat W1C
    always_comb begin
        tx_d = tx_q;
        rx_d = rx_q;
        for (int i = 0; i < int'(N); i++) begin
            if (wr_en && (offset == address_width'(i))) tx_d[i] = data_i[7:0];
            if (capture) rx_d[i] = rx_shift_q[FRAME_BITS-1-8*i -: 8];
        end
        w1c         = (wr_en && (offset == STATUS_A)) ? data_i[3:0] : 4'b0;
        rx_valid_d  = (rx_valid_q  & ~w1c[STAT_RX_VALID])  | capture;
        overrun_d   = (overrun_q   & ~w1c[STAT_OVERRUN])   | (capture & rx_valid_q);
        frame_err_d = (frame_err_q & ~w1c[STAT_FRAME_ERR]) | set_ferr;
        irq_en_d    = (wr_en && (offset == CTRL_A)) ? data_i[0] : irq_en_q;
        data_d      = rd_en ? data_width'(rd_data) : data_q;
        irq_d       = irq_en_q & rx_valid_q;
    end

    // CPU-side registers
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            for (int i = 0; i < int'(N); i++) begin
                tx_q[i] <= '0;
                rx_q[i] <= '0;
            end
            rx_valid_q  <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
            irq_en_q    <= 1'b0;
            irq_q       <= 1'b0;
            data_q      <= '0;
        end else begin
            tx_q        <= tx_d;
            rx_q        <= rx_d;
            rx_valid_q  <= rx_valid_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
            irq_en_q    <= irq_en_d;
            irq_q       <= irq_d;
            data_q      <= data_d;
        end
    end

    assign data_o = data_q;
    assign irq_o  = irq_q;

endmodule

// File: doc/spi_slave_6502.md
Name: spi_slave_6502

Overview:
- SPI peripheral-mode (slave) endpoint on the 6502 data bus. It is the far-end counterpart of the SoC's SPI master, letting an external SPI host exchange fixed-length frames with the CPU.
- The CPU loads a TX buffer and reads back the RX buffer, status and control through memory-mapped registers.
- It slots into the top-level address map as one more bus entry, with its own data_reg_inputs slot and an optional IRQ source.

Parameters:
- BaseAddress, 'h9400, first bus address of register window
- BytesPerTransaction, 4, bytes per SPI frame (N); 1..8
- address_width, 16, CPU address width
- data_width, 8, CPU data width
- SyncStages, 2, synchronizer depth on spi_clk_i/spi_cs_ni/spi_mosi_i; >=2

Ports:
- clk_i  in  1  system clock; all logic in this domain
- reset_ni  in  1  asynchronous, active-low reset
- address_i  in  address_width  CPU address (unregistered AB)
- data_i  in  data_width  CPU write data
- rd_wr_i  in  1  1 = write, 0 = read (CPU WE)
- data_o  out  data_width  registered read data to bus mux
- spi_clk_i  in  1  SCLK from external host, mode 0
- spi_cs_ni  in  1  chip select, active-low
- spi_mosi_i  in  1  host-to-slave data
- spi_miso_o  out  1  slave-to-host data; 0 while CS high
- irq_o  out  1  registered interrupt request, level

Behaviour:
- Register map, offsets from BaseAddress (N = BytesPerTransaction):
  - 0..N-1: TX buffer, R/W.
  - N..2N-1: RX buffer, RO.
  - 2N: STATUS.
    - bit0 rx_valid, W1C
    - bit1 busy (RO, CS active)
    - bit2 overrun, W1C
    - bit3 frame_error, W1C
  - 2N+1: CTRL, bit0 irq_en.
  - Unused bits read 0. Writes to RO or out-of-window offsets are ignored.
- Bus read: data_o updates on the clk_i edge where address_i is in the window and rd_wr_i=0, which matches the top's registered address_reg mux. Otherwise data_o holds its value.
- Bus write: takes effect on the clk_i edge where rd_wr_i=1 and the address hits.
- Reset (reset_ni=0, async): all buffers, STATUS, CTRL, data_o, irq_o and spi_miso_o are 0; FSM goes to IDLE. A frame in progress is discarded silently, with no frame_error.
- Inputs pass through SyncStages flops, then a one-flop edge detect. Required: SCLK half-period >= SyncStages+2 clk_i cycles, and CS-fall-to-first-SCLK-rise >= SyncStages+2 cycles.
- SPI framing: mode 0 (CPOL=0, CPHA=0), MSB first, byte 0 first.
- FSM states:
  - IDLE: on sync CS fall, load tx_shift = {TX[0],...,TX[N-1]}, clear bit_cnt, set busy; go to ACTIVE.
  - ACTIVE:
    - On sync SCLK rise: rx_shift <= {rx_shift, mosi_sync}, bit_cnt+1.
    - On sync SCLK fall: tx_shift shifts left by 1.
    - When bit_cnt reaches 8N: go to COMPLETE.
    - On CS rise before 8N bits: set frame_error, leave RX buffer untouched, clear busy; go to IDLE.
  - COMPLETE (1 cycle): copy rx_shift into RX[0..N-1] and set rx_valid. If rx_valid was already 1, also set overrun (new data overwrites). Go to WAIT_CS.
  - WAIT_CS: ignore further SCLK edges and hold spi_miso_o at 0. On CS rise, clear busy; go to IDLE.
- spi_miso_o = tx_shift MSB while state is ACTIVE, else 0. Registered; no tristate inside the block.
- TX buffer is snapshotted at CS fall. CPU writes during a frame affect the next frame only.
- bit_cnt width is $clog2(8N+1).
- irq_o <= irq_en & rx_valid, registered, 1-cycle lag.
- Simultaneous events:
  - A hardware set of rx_valid/overrun/frame_error beats a same-cycle W1C of that bit.
  - A CPU RX read in the COMPLETE cycle returns the old RX data.
  - CS rise in the same synced cycle as the 8N-th SCLK rise counts as complete, not an error.
- Latency: the 8N-th synced SCLK rise is detected at cycle T, giving COMPLETE at T+1. RX buffer and rx_valid are visible at T+2, and irq_o asserts at T+3.

Decomposition:
- Package spi_slave_6502_pkg holds:
  - the state enum {IDLE, ACTIVE, COMPLETE, WAIT_CS}
  - STATUS bit-index constants
  - register-offset functions of N
- Sub-module sync_edge: SyncStages-deep synchronizer plus rise/fall pulse outputs, instantiated for SCLK and CS; MOSI uses the sync only.
- Bus register decode stays in the top of this block.

Test Plan:
1. N=4, CPU writes TX = 'hA5,'h3C,'h00,'hFF; host sends 'h11,'h22,'h33,'h44 with SCLK = clk_i/10 -> MISO stream is A5 3C 00 FF; RX offsets 4..7 read 11 22 33 44; STATUS = 'h01.
2. Set CTRL = 1 and complete a frame -> irq_o rises 3 cycles after the last synced SCLK rise. Writing STATUS = 'h01 drops irq_o the cycle after the write; STATUS then reads 'h00.
3. Send two full frames without clearing rx_valid -> RX holds the second frame's data; STATUS = 'h05.
4. Raise CS after 13 bits -> STATUS = 'h08, RX unchanged, FSM returns to IDLE. The next full frame is received correctly.
5. Pulse reset_ni low mid-frame at bit 20 -> all registers 0 and spi_miso_o = 0 immediately (async). A fresh frame after release is received correctly.
6. CPU writes TX[0] = 'h77 mid-frame -> the current frame still shifts the old TX[0], and the following frame shifts 'h77. Extra SCLK pulses in WAIT_CS leave RX unchanged and keep spi_miso_o at 0.
